goomba_motion: RTL and testbench

Per-Goomba motion and interaction controller, paired with the Goomba sprite-state block. It walks the enemy along the direction that block reports, applies gravity, and detects walls and screen edges. It also checks the enemy box against Mario's box every cycle. Walls and edges produce the `collapsion_impulse` toggle, stomps produce the `press_impulse` toggle, and side contact produces a `mario_hit` pulse. Its `x`/`y` go to the renderer and to the map-collision block.

---
 rtl/goomba_motion.sv | 189 ++++++++++++++++++
 tb/tb_goomba_motion.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/goomba_motion.sv
// goomba_motion: per-Goomba motion and interaction controller.
// Walks the enemy in the direction reported by the sprite-state block, reverses
// at walls/screen edges, detects stomps and side hits against Mario's box.
// Define GOOMBA_GRAVITY_EN to enable falling (FALL/GONE states, vy, fell);
// without it y stays at INIT_Y, on_ground is ignored and fell is tied to 0.
module goomba_motion #(
    parameter int TICK_DIV     = 1000000,
    parameter int SPEED        = 1,
    parameter int INIT_X       = 400,
    parameter int INIT_Y       = 100,
    parameter int GRAVITY_MAX  = 4,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int STOMP_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  id,
    input  logic        live,
    input  logic        oriental,
    input  logic [10:0] w,
    input  logic [10:0] h,
    input  logic        blocked_left,
    input  logic        blocked_right,
    input  logic        on_ground,
    input  logic [10:0] mario_x,
    input  logic [10:0] mario_y,
    input  logic [10:0] mario_w,
    input  logic [10:0] mario_h,
    input  logic        mario_falling,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        collapsion_impulse,
    output logic        press_impulse,
    output logic        mario_hit,
    output logic        fell
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [10:0] INIT_X11   = 11'(INIT_X);
    localparam logic [10:0] INIT_Y11   = 11'(INIT_Y);
    localparam logic [10:0] SPEED11    = 11'(SPEED);
    localparam logic [11:0] SPEED12    = 12'(SPEED);
    localparam logic [11:0] SCREEN_W12 = 12'(SCREEN_W);
    localparam logic [11:0] MARGIN12   = 12'(STOMP_MARGIN);
    localparam logic [5:0]  ID_HIDDEN  = 6'd63;

    typedef enum logic [2:0] {S_HIDDEN, S_WALK, S_FALL, S_FROZEN, S_GONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      x_q, x_d, y_q, y_d;
    logic             coll_q, coll_d, press_q, press_d, hit_q, hit_d;
    logic             pressed_q, pressed_d, prev_ov_q, prev_ov_d;
    logic             step, overlap, stomp_cond, stomp_fire, wall;
`ifdef GOOMBA_GRAVITY_EN
    logic [3:0]       vy_q, vy_d, vy_nxt;
    logic             fell_q, fell_d;
    localparam logic [3:0]  GMAX4 = 4'(GRAVITY_MAX);
    localparam logic [11:0] SCREEN_H12 = 12'(SCREEN_H);
`else
    logic             unused_on_ground;
    assign unused_on_ground = on_ground;
`endif

    // Step strobe, box overlap, stomp and wall qualification (12-bit sums, no wrap)
    always_comb begin
        step       = (cnt_q == CNT_LAST);
        overlap    = ({1'b0, x_q} < {1'b0, mario_x} + {1'b0, mario_w}) &&
                     ({1'b0, mario_x} < {1'b0, x_q} + {1'b0, w}) &&
                     ({1'b0, y_q} < {1'b0, mario_y} + {1'b0, mario_h}) &&
                     ({1'b0, mario_y} < {1'b0, y_q} + {1'b0, h});
        stomp_cond = overlap && mario_falling &&
                     ({1'b0, mario_y} + {1'b0, mario_h} <= {1'b0, y_q} + MARGIN12);
        stomp_fire = stomp_cond && !pressed_q;
        // Facing left, x is unsigned so clamping to max(x,0) is simply holding x
        wall       = oriental ? (blocked_left || ({1'b0, x_q} < SPEED12))
                              : (blocked_right || ({1'b0, x_q} + {1'b0, w} + SPEED12 > SCREEN_W12));
    end

    // Next-state: forced states first, then interaction, then stepped motion
    always_comb begin
        state_d   = state_q;
        cnt_d     = step ? '0 : cnt_q + CNT_W'(1);
        x_d       = x_q;
        y_d       = y_q;
        coll_d    = coll_q;
        press_d   = press_q;
        hit_d     = 1'b0;
        pressed_d = pressed_q;
        prev_ov_d = overlap;
`ifdef GOOMBA_GRAVITY_EN
        vy_d      = vy_q;
        fell_d    = fell_q;
        vy_nxt    = (vy_q >= GMAX4) ? GMAX4 : vy_q + 4'd1;
`endif
        if (state_q == S_GONE) begin
            state_d = S_GONE;
        end else if (id == ID_HIDDEN) begin
            state_d = S_HIDDEN;
        end else if (!live) begin
            state_d = S_FROZEN;
        end else if (state_q == S_HIDDEN) begin
            state_d = S_WALK;
        end else if (state_q == S_WALK || state_q == S_FALL) begin
            if (stomp_fire) begin
                press_d   = ~press_q;
                pressed_d = 1'b1;
                state_d   = S_FROZEN;
            end
            // A stomp-qualified contact never also counts as a hit
            if (overlap && !prev_ov_q && !stomp_cond)
                hit_d = 1'b1;
            if (step) begin
                if (wall)
                    coll_d = ~coll_q;
                // The stomp's freeze wins over the move on the same cycle
                if (!stomp_fire) begin
                    if (!wall)
                        x_d = oriental ? x_q - SPEED11 : x_q + SPEED11;
`ifdef GOOMBA_GRAVITY_EN
                    if (state_q == S_WALK) begin
                        if (!on_ground) begin
                            state_d = S_FALL;
                            vy_d    = 4'd1;
                        end
                    end else if (on_ground) begin
                        state_d = S_WALK;
                        vy_d    = 4'd0;
                    end else begin
                        y_d  = y_q + 11'(vy_q);
                        vy_d = vy_nxt;
                        if ({1'b0, y_q} + 12'(vy_q) + 12'(vy_nxt) >= SCREEN_H12) begin
                            state_d = S_GONE;
                            fell_d  = 1'b1;
                        end
                    end
`endif
                end
            end
        end
    end

    // State, position and pulse registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_WALK;
            cnt_q     <= '0;
            x_q       <= INIT_X11;
            y_q       <= INIT_Y11;
            coll_q    <= 1'b0;
            press_q   <= 1'b0;
            hit_q     <= 1'b0;
            pressed_q <= 1'b0;
            prev_ov_q <= 1'b0;
`ifdef GOOMBA_GRAVITY_EN
            vy_q      <= 4'd0;
            fell_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            coll_q    <= coll_d;
            press_q   <= press_d;
            hit_q     <= hit_d;
            pressed_q <= pressed_d;
            prev_ov_q <= prev_ov_d;
`ifdef GOOMBA_GRAVITY_EN
            vy_q      <= vy_d;
            fell_q    <= fell_d;
`endif
        end
    end

    assign x                  = x_q;
    assign y                  = y_q;
    assign collapsion_impulse = coll_q;
    assign press_impulse      = press_q;
    assign mario_hit          = hit_q;
`ifdef GOOMBA_GRAVITY_EN
    assign fell               = fell_q;
`else
    assign fell               = 1'b0;
`endif

endmodule

// File: tb/tb_goomba_motion.sv
// tb_goomba_motion: directed scenarios plus randomized traffic for goomba_motion,
// checked every cycle against a behavioural model of the Goomba's rules.
// Honours GOOMBA_GRAVITY_EN the same way the design does.
module tb_goomba_motion;

    localparam int TICK_DIV = 4;
    localparam int SPEED    = 1;
    localparam int INIT_X   = 2;
    localparam int INIT_Y   = 100;
    localparam int GMAX     = 4;
    localparam int SCR_W    = 64;
    localparam int SCR_H    = 160;
    localparam int MARGIN   = 4;

    localparam int M_HIDDEN = 0, M_WALK = 1, M_FALL = 2, M_FROZEN = 3, M_GONE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  id;
    logic        live, oriental, blocked_left, blocked_right, on_ground, mario_falling;
    logic [10:0] w, h, mario_x, mario_y, mario_w, mario_h;
    logic [10:0] x, y;
    logic        collapsion_impulse, press_impulse, mario_hit, fell;

    goomba_motion #(
        .TICK_DIV(TICK_DIV), .SPEED(SPEED), .INIT_X(INIT_X), .INIT_Y(INIT_Y),
        .GRAVITY_MAX(GMAX), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .STOMP_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rstn(rstn), .id(id), .live(live), .oriental(oriental),
        .w(w), .h(h), .blocked_left(blocked_left), .blocked_right(blocked_right),
        .on_ground(on_ground), .mario_x(mario_x), .mario_y(mario_y),
        .mario_w(mario_w), .mario_h(mario_h), .mario_falling(mario_falling),
        .x(x), .y(y), .collapsion_impulse(collapsion_impulse),
        .press_impulse(press_impulse), .mario_hit(mario_hit), .fell(fell)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int mode; int x; int y; int vy; int cnt;
        int coll; int press; int hit; int fell; int pressed; int prev;
    } mdl_t;

    mdl_t m;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic mdl_t reset_state();
        mdl_t r;
        r = '0;
        r.mode = M_WALK;
        r.x = INIT_X;
        r.y = INIT_Y;
        return r;
    endfunction

    // One clock of the Goomba's behaviour from the current inputs
    function automatic mdl_t predict(mdl_t c);
        mdl_t n;
        bit   stp, ov, stomp, blk;
        int   mx, my, mw, mh, gw, gh;
        n  = c;
        mx = int'(mario_x); my = int'(mario_y); mw = int'(mario_w); mh = int'(mario_h);
        gw = int'(w);       gh = int'(h);
        n.hit = 0;
        if (!rstn) return reset_state();
        stp    = (c.cnt == TICK_DIV - 1);
        n.cnt  = stp ? 0 : c.cnt + 1;
        ov     = (c.x < mx + mw) && (mx < c.x + gw) && (c.y < my + mh) && (my < c.y + gh);
        n.prev = int'(ov);
        if (c.mode == M_GONE) return n;
        if (id == 6'd63) begin n.mode = M_HIDDEN; return n; end
        if (!live) begin n.mode = M_FROZEN; return n; end
        if (c.mode == M_HIDDEN) begin n.mode = M_WALK; return n; end
        if (c.mode == M_FROZEN) return n;
        stomp = ov && mario_falling && (my + mh <= c.y + MARGIN);
        if (stomp && c.pressed == 0) begin
            n.press = 1 - c.press; n.pressed = 1; n.mode = M_FROZEN;
        end
        if (ov && c.prev == 0 && !stomp) n.hit = 1;
        if (!stp) return n;
        if (oriental) blk = blocked_left || (c.x < SPEED);
        else          blk = blocked_right || (c.x + gw + SPEED > SCR_W);
        if (blk) n.coll = 1 - c.coll;
        if (n.mode == M_FROZEN) return n;
        if (!blk) n.x = oriental ? c.x - SPEED : c.x + SPEED;
`ifdef GOOMBA_GRAVITY_EN
        if (c.mode == M_WALK) begin
            if (!on_ground) begin n.mode = M_FALL; n.vy = 1; end
        end else if (on_ground) begin
            n.mode = M_WALK; n.vy = 0;
        end else begin
            n.y  = c.y + c.vy;
            n.vy = (c.vy + 1 > GMAX) ? GMAX : c.vy + 1;
            if (n.y + n.vy >= SCR_H) begin n.mode = M_GONE; n.fell = 1; end
        end
`endif
        return n;
    endfunction

    task automatic cycle();
        mdl_t nx;
        nx = predict(m);
        @(posedge clk);
        #1;
        m = nx;
        check("x", 32'(x), 32'(m.x));
        check("y", 32'(y), 32'(m.y));
        check("collapsion", 32'(collapsion_impulse), 32'(m.coll));
        check("press", 32'(press_impulse), 32'(m.press));
        check("mario_hit", 32'(mario_hit), 32'(m.hit));
        check("fell", 32'(fell), 32'(m.fell));
    endtask

    task automatic mario_far();
        mario_x = 11'd1000; mario_y = 11'd1000; mario_w = 11'd1; mario_h = 11'd1;
        mario_falling = 1'b0;
    endtask

    int fall_exp [6] = '{101, 103, 106, 110, 114, 118};

    initial begin
        int c0, x0, y0, pulses, v;
        m = reset_state();
        rstn = 1'b0; id = 6'd10; live = 1'b1; oriental = 1'b1;
        w = 11'd16; h = 11'd16; blocked_left = 1'b0; blocked_right = 1'b0; on_ground = 1'b1;
        mario_far();

        // Reset state
        repeat (2) cycle();
        check("rst_x", 32'(x), 32'(INIT_X));
        check("rst_y", 32'(y), 32'(INIT_Y));
        check("rst_coll", 32'(collapsion_impulse), 32'd0);
        check("rst_press", 32'(press_impulse), 32'd0);

        // Walk left to the screen edge, then reverse request
        rstn = 1'b1;
        repeat (4) cycle();
        check("walk_x_c4", 32'(x), 32'd1);
        repeat (4) cycle();
        check("walk_x_c8", 32'(x), 32'd0);
        repeat (3) cycle();
        check("edge_coll_before", 32'(collapsion_impulse), 32'd0);
        cycle();
        check("edge_coll_c12", 32'(collapsion_impulse), 32'd1);
        check("edge_x_c12", 32'(x), 32'd0);

        // Gravity
        on_ground = 1'b0;
`ifdef GOOMBA_GRAVITY_EN
        repeat (4) cycle();
        check("fall_start_y", 32'(y), 32'd100);
        foreach (fall_exp[i]) begin
            repeat (4) cycle();
            check("fall_y", 32'(y), 32'(fall_exp[i]));
        end
        on_ground = 1'b1;
        repeat (4) cycle();
        check("land_y", 32'(y), 32'd118);
        repeat (8) cycle();
        check("land_hold_y", 32'(y), 32'd118);
`else
        repeat (12) cycle();
        check("nograv_y", 32'(y), 32'(INIT_Y));
        on_ground = 1'b1;
`endif

        // Wall reversal facing right
        oriental = 1'b0; blocked_right = 1'b1;
        c0 = m.coll; x0 = m.x;
        repeat (4) cycle();
        check("wall_coll", 32'(collapsion_impulse), 32'(1 - c0));
        check("wall_x", 32'(x), 32'(x0));
        blocked_right = 1'b0;
        repeat (4) cycle();
        check("walk_right_x", 32'(x), 32'(x0 + 1));

        // Stomp from above, then held overlap and live drop
        mario_x = 11'(m.x); mario_y = 11'(m.y - 14); mario_w = 11'd16; mario_h = 11'd16;
        mario_falling = 1'b1;
        cycle();
        check("stomp_press", 32'(press_impulse), 32'd1);
        repeat (10) cycle();
        live = 1'b0;
        x0 = m.x; y0 = m.y;
        repeat (8) cycle();
        check("stomp_once", 32'(press_impulse), 32'd1);
        check("frozen_x", 32'(x), 32'(x0));
        check("frozen_y", 32'(y), 32'(y0));

        // Side hit: revive through HIDDEN, then overlap from the side
        mario_far();
        id = 6'd63; cycle();
        id = 6'd10; live = 1'b1; cycle();
        cycle();
        mario_x = 11'(m.x + 10); mario_y = 11'(m.y); mario_w = 11'd16; mario_h = 11'd16;
        mario_falling = 1'b0;
        cycle();
        check("hit_first", 32'(mario_hit), 32'd1);
        pulses = int'(mario_hit);
        repeat (19) begin
            cycle();
            pulses += int'(mario_hit);
        end
        check("hit_pulses", 32'(pulses), 32'd1);

        // Hidden: nothing moves, nothing pulses
        mario_far();
        id = 6'd63;
        x0 = m.x; y0 = m.y; c0 = m.coll; pulses = 0;
        repeat (12) begin
            cycle();
            pulses += int'(mario_hit);
        end
        check("hidden_x", 32'(x), 32'(x0));
        check("hidden_y", 32'(y), 32'(y0));
        check("hidden_coll", 32'(collapsion_impulse), 32'(c0));
        check("hidden_hit", 32'(pulses), 32'd0);

        // Reset in the middle of a fall
        id = 6'd10; on_ground = 1'b0;
        repeat (13) cycle();
        rstn = 1'b0;
        cycle();
        check("midrst_x", 32'(x), 32'(INIT_X));
        check("midrst_y", 32'(y), 32'(INIT_Y));
        check("midrst_outs", {28'd0, collapsion_impulse, press_impulse, mario_hit, fell}, 32'd0);
        rstn = 1'b1; on_ground = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            v = int'($urandom_range(0, 19));
            id = (v == 0) ? 6'd63 : ((v < 10) ? 6'd10 : 6'd12);
            live = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 15) == 0) oriental = ~oriental;
            blocked_left  = ($urandom_range(0, 7) == 0);
            blocked_right = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) on_ground = ~on_ground;
            if (!rstn) begin
                w = 11'($urandom_range(4, 20));
                h = 11'($urandom_range(4, 20));
            end
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 2) == 0) mario_far();
                else begin
                    v = m.x + int'($urandom_range(0, 40)) - 20;
                    mario_x = 11'((v < 0) ? 0 : v);
                    v = m.y + int'($urandom_range(0, 48)) - 24;
                    mario_y = 11'((v < 0) ? 0 : v);
                    mario_w = 11'($urandom_range(4, 20));
                    mario_h = 11'($urandom_range(4, 20));
                    mario_falling = 1'($urandom_range(0, 1));
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
